// File: rtl/matriz_leds_param.sv
// LED-matrix puzzle engine: button sync/edge detect, XOR region toggling,
// target-row completion flag with input lock, and a prescaled row scanner.
module matriz_leds_param #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int NBTN           = 8,
  parameter int SCAN_DIV       = 1024,
  parameter int ROW_ACTIVE_LOW = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         limpar,
  input  logic [NBTN-1:0]              botoes,
  input  logic [NBTN*ROWS*COLS-1:0]    mascaras,
  input  logic [$clog2(ROWS+1)-1:0]    linhas_alvo,
  output logic                         nivel_concluido,
  output logic [7:0]                   jogadas,
  output logic [COLS-1:0]              colunas,
  output logic [ROWS-1:0]              linhas,
  output logic [$clog2(ROWS)-1:0]      db_linha
);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(ROWS + 1);
  localparam int RW    = $clog2(ROWS);
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NBTN-1:0]  s1_q, s2_q, s3_q;
  logic [NBTN-1:0]  press, accepted;
  logic [CELLS-1:0] state_q, state_d, toggle;
  logic [7:0]       jog_q, jog_d;
  logic             done_q, done_d;
  logic [ROWS-1:0]  row_ok;
  logic [PW-1:0]    presc_q, presc_d;
  logic [RW-1:0]    row_q, row_d;
  logic             presc_tc;
  logic [ROWS-1:0]  row_onehot;

  assign press    = s2_q & ~s3_q;
  assign accepted = press & {NBTN{~done_q & ~limpar}};

  always_comb begin
    toggle = '0;
    for (int b = 0; b < NBTN; b++) begin
      if (accepted[b]) toggle = toggle ^ mascaras[b*CELLS +: CELLS];
    end
  end

  // A row is "ok" when it lies outside the target band or is all-ones;
  // a target larger than ROWS simply makes every row required.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign row_ok[gi] = (AW'(gi) >= linhas_alvo) || (&state_q[gi*COLS +: COLS]);
  end

  always_comb begin
    state_d = state_q ^ toggle;
    jog_d   = jog_q;
    done_d  = (linhas_alvo != '0) && (&row_ok);
    if ((|accepted) && (jog_q != 8'hFF)) jog_d = jog_q + 8'd1;
    if (limpar) begin
      state_d = '0;
      jog_d   = '0;
      done_d  = 1'b0;
    end
  end

  assign presc_tc = (presc_q == PW'(SCAN_DIV - 1));

  always_comb begin
    presc_d = presc_q + 1'b1;
    row_d   = row_q;
    if (presc_tc) begin
      presc_d = '0;
      row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      state_q <= '0;
      jog_q   <= '0;
      done_q  <= 1'b0;
      presc_q <= '0;
      row_q   <= '0;
    end else begin
      s1_q    <= botoes;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      jog_q   <= jog_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      row_q   <= row_d;
    end
  end

  assign row_onehot      = ROWS'(1) << row_q;
  assign linhas          = (ROW_ACTIVE_LOW != 0) ? ~row_onehot : row_onehot;
  assign colunas         = state_q[row_q*COLS +: COLS];
  assign db_linha        = row_q;
  assign jogadas         = jog_q;
  assign nivel_concluido = done_q;

endmodule

// File: tb/tb_matriz_leds_param.sv
// Directed self-checking bench: a default-size instance for game logic and a
// small 5x4 instance for the row scanner.
module tb_matriz_leds_param;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         limpar_a = 1'b0, limpar_b = 1'b0;
  logic [7:0]   botoes_a = '0;
  logic [1:0]   botoes_b = '0;
  logic [511:0] masc_a = '0;
  logic [39:0]  masc_b = '0;
  logic [3:0]   alvo_a = '0;
  logic [2:0]   alvo_b = '0;
  logic         nivel_a, nivel_b;
  logic [7:0]   jog_a, jog_b;
  logic [7:0]   col_a;
  logic [3:0]   col_b;
  logic [7:0]   lin_a;
  logic [4:0]   lin_b;
  logic [2:0]   db_a, db_b;
  int           total = 0, bad = 0, cyc;

  matriz_leds_param dut_a (
    .clk(clk), .rst_n(rst_n), .limpar(limpar_a), .botoes(botoes_a),
    .mascaras(masc_a), .linhas_alvo(alvo_a), .nivel_concluido(nivel_a),
    .jogadas(jog_a), .colunas(col_a), .linhas(lin_a), .db_linha(db_a)
  );

  matriz_leds_param #(.ROWS(5), .COLS(4), .NBTN(2), .SCAN_DIV(4), .ROW_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .limpar(limpar_b), .botoes(botoes_b),
    .mascaras(masc_b), .linhas_alvo(alvo_b), .nivel_concluido(nivel_b),
    .jogadas(jog_b), .colunas(col_b), .linhas(lin_b), .db_linha(db_b)
  );

  always #5 clk = ~clk;

  // edges since the last reset release, for the scanner model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_a(input logic [7:0] m);
    botoes_a = m;
    tick();
    botoes_a = '0;
    tick();
    tick();
  endtask

  task automatic read_row(input int r, output logic [7:0] v);
    int n;
    n = 0;
    while (int'(db_a) != r && n < 10000) begin
      tick();
      n++;
    end
    if (n >= 10000) begin
      total++; bad++;
      $display("FAIL read_row: timeout waiting for row %0d, db_linha=%0d", r, db_a);
    end
    v = col_a;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++; if (col_a !== 8'h00) begin bad++; $display("FAIL rst_colunas: got %h want 00", col_a); end
    total++; if (lin_a !== 8'hFE) begin bad++; $display("FAIL rst_linhas: got %h want fe", lin_a); end
    total++; if (db_a !== 3'd0) begin bad++; $display("FAIL rst_db_linha: got %0d want 0", db_a); end
    total++; if (jog_a !== 8'd0) begin bad++; $display("FAIL rst_jogadas: got %0d want 0", jog_a); end
    total++; if (nivel_a !== 1'b0) begin bad++; $display("FAIL rst_nivel: got %b want 0", nivel_a); end
    total++; if (lin_b !== 5'b00001) begin bad++; $display("FAIL rst_linhas_b: got %b want 00001", lin_b); end
    rst_n = 1'b1;
  endtask

  task automatic test_press();
    logic [7:0] v;
    botoes_a = 8'h01;
    tick();
    tick();
    total++; if (col_a !== 8'h00) begin bad++; $display("FAIL press_e2_col: got %h want 00", col_a); end
    total++; if (jog_a !== 8'd0) begin bad++; $display("FAIL press_e2_jog: got %0d want 0", jog_a); end
    tick();
    total++; if (col_a !== 8'h07) begin bad++; $display("FAIL press_e3_col: got %h want 07", col_a); end
    total++; if (jog_a !== 8'd1) begin bad++; $display("FAIL press_e3_jog: got %0d want 1", jog_a); end
    repeat (7) tick();
    botoes_a = '0;
    repeat (3) tick();
    total++; if (col_a !== 8'h07) begin bad++; $display("FAIL press_held_col: got %h want 07", col_a); end
    total++; if (jog_a !== 8'd1) begin bad++; $display("FAIL press_held_jog: got %0d want 1", jog_a); end
    read_row(1, v);
    total++; if (v !== 8'h07) begin bad++; $display("FAIL press_row1: got %h want 07", v); end
    read_row(2, v);
    total++; if (v !== 8'h07) begin bad++; $display("FAIL press_row2: got %h want 07", v); end
    press_a(8'h01);
    total++; if (col_a !== 8'h00) begin bad++; $display("FAIL press2_row2: got %h want 00", col_a); end
    total++; if (jog_a !== 8'd2) begin bad++; $display("FAIL press2_jog: got %0d want 2", jog_a); end
  endtask

  task automatic test_scanner();
    logic [3:0] exp_rows [5];
    logic [4:0] one5;
    int         r;
    exp_rows = '{4'h0, 4'hF, 4'h0, 4'h1, 4'h4};
    one5 = 5'd1;
    botoes_b = 2'b11;
    tick();
    botoes_b = 2'b00;
    repeat (3) tick();
    for (int i = 0; i < 25; i++) begin
      r = (cyc / 4) % 5;
      total++; if (int'(db_b) != r) begin bad++; $display("FAIL scan_db: cyc=%0d got %0d want %0d", cyc, db_b, r); end
      total++; if (lin_b !== (one5 << r)) begin bad++; $display("FAIL scan_linhas: cyc=%0d got %b want %b", cyc, lin_b, one5 << r); end
      total++; if (col_b !== exp_rows[r]) begin bad++; $display("FAIL scan_col: cyc=%0d got %h want %h", cyc, col_b, exp_rows[r]); end
      tick();
    end
    total++; if (jog_b !== 8'd1) begin bad++; $display("FAIL scan_jog_b: got %0d want 1", jog_b); end
  endtask

  task automatic test_overlap();
    logic [7:0] v;
    press_a(8'h0C);
    total++; if (jog_a !== 8'd3) begin bad++; $display("FAIL overlap_jog: got %0d want 3", jog_a); end
    read_row(5, v);
    total++; if (v !== 8'h77) begin bad++; $display("FAIL overlap_row5: got %h want 77", v); end
    total++; if (lin_a !== 8'hDF) begin bad++; $display("FAIL overlap_linhas: got %h want df", lin_a); end
    read_row(6, v);
    total++; if (v !== 8'hFF) begin bad++; $display("FAIL overlap_row6: got %h want ff", v); end
  endtask

  task automatic test_completion();
    logic [7:0] v;
    limpar_a = 1'b1;
    tick();
    limpar_a = 1'b0;
    total++; if (jog_a !== 8'd0) begin bad++; $display("FAIL clr_jog: got %0d want 0", jog_a); end
    total++; if (col_a !== 8'h00) begin bad++; $display("FAIL clr_col: got %h want 00", col_a); end
    alvo_a = 4'd1;
    press_a(8'h10);
    tick();
    total++; if (nivel_a !== 1'b0) begin bad++; $display("FAIL comp_half: got %b want 0", nivel_a); end
    press_a(8'h20);
    total++; if (nivel_a !== 1'b0) begin bad++; $display("FAIL comp_e3: got %b want 0", nivel_a); end
    tick();
    total++; if (nivel_a !== 1'b1) begin bad++; $display("FAIL comp_e4: got %b want 1", nivel_a); end
    press_a(8'h01);
    tick();
    total++; if (jog_a !== 8'd2) begin bad++; $display("FAIL lock_jog: got %0d want 2", jog_a); end
    total++; if (nivel_a !== 1'b1) begin bad++; $display("FAIL lock_nivel: got %b want 1", nivel_a); end
    read_row(0, v);
    total++; if (v !== 8'hFF) begin bad++; $display("FAIL lock_row0: got %h want ff", v); end
    limpar_a = 1'b1;
    tick();
    limpar_a = 1'b0;
    total++; if (nivel_a !== 1'b0) begin bad++; $display("FAIL clr2_nivel: got %b want 0", nivel_a); end
    total++; if (col_a !== 8'h00) begin bad++; $display("FAIL clr2_col: got %h want 00", col_a); end
    total++; if (jog_a !== 8'd0) begin bad++; $display("FAIL clr2_jog: got %0d want 0", jog_a); end
    alvo_a = 4'd0;
    press_a(8'h30);
    tick();
    tick();
    total++; if (nivel_a !== 1'b0) begin bad++; $display("FAIL alvo0_nivel: got %b want 0", nivel_a); end
    total++; if (jog_a !== 8'd1) begin bad++; $display("FAIL alvo0_jog: got %0d want 1", jog_a); end
    alvo_a = 4'd15;
    tick();
    total++; if (nivel_a !== 1'b0) begin bad++; $display("FAIL alvo15_nivel: got %b want 0", nivel_a); end
    alvo_a = 4'd1;
    tick();
    total++; if (nivel_a !== 1'b1) begin bad++; $display("FAIL alvo1_nivel: got %b want 1", nivel_a); end
    limpar_a = 1'b1;
    tick();
    limpar_a = 1'b0;
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 300; i++) begin
      press_a(8'h02);
      if (i == 200) begin
        total++; if (jog_a !== 8'd200) begin bad++; $display("FAIL sat_200: got %0d want 200", jog_a); end
      end
      if (i == 255) begin
        total++; if (jog_a !== 8'd255) begin bad++; $display("FAIL sat_255: got %0d want 255", jog_a); end
      end
    end
    total++; if (jog_a !== 8'd255) begin bad++; $display("FAIL sat_300: got %0d want 255", jog_a); end
    limpar_a = 1'b1;
    tick();
    limpar_a = 1'b0;
    total++; if (jog_a !== 8'd0) begin bad++; $display("FAIL sat_clr: got %0d want 0", jog_a); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    press_a(8'h01);
    read_row(1, v);
    total++; if (v !== 8'h07) begin bad++; $display("FAIL mid_pre: got %h want 07", v); end
    rst_n = 1'b0;
    #1;
    total++; if (col_a !== 8'h00) begin bad++; $display("FAIL mid_col: got %h want 00", col_a); end
    total++; if (lin_a !== 8'hFE) begin bad++; $display("FAIL mid_linhas: got %h want fe", lin_a); end
    total++; if (db_a !== 3'd0) begin bad++; $display("FAIL mid_db: got %0d want 0", db_a); end
    total++; if (jog_a !== 8'd0) begin bad++; $display("FAIL mid_jog: got %0d want 0", jog_a); end
    total++; if (nivel_a !== 1'b0) begin bad++; $display("FAIL mid_nivel: got %b want 0", nivel_a); end
    tick();
    rst_n = 1'b1;
    botoes_a = 8'h01;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    botoes_a = '0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    total++; if (jog_a !== 8'd0) begin bad++; $display("FAIL inflight_jog: got %0d want 0", jog_a); end
    total++; if (col_a !== 8'h00) begin bad++; $display("FAIL inflight_col: got %h want 00", col_a); end
  endtask

  initial begin
    for (int r = 0; r < 3; r++) masc_a[0*64 + r*8 +: 8] = 8'h07;
    masc_a[2*64 + 5*8 +: 8] = 8'h0F;
    masc_a[3*64 + 5*8 +: 8] = 8'h78;
    masc_a[3*64 + 6*8 +: 8] = 8'hFF;
    masc_a[4*64 + 0*8 +: 8] = 8'h0F;
    masc_a[5*64 + 0*8 +: 8] = 8'hF0;
    masc_b[0*20 + 1*4 +: 4] = 4'hF;
    masc_b[20 + 12] = 1'b1;
    masc_b[20 + 18] = 1'b1;
    test_reset();
    test_press();
    test_scanner();
    test_overlap();
    test_completion();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matriz_leds_param.md
# matriz_leds_param

Parametrised LED-matrix puzzle engine, successor to the fixed 8×8 controller. It synchronises and edge-detects the physical buttons. Each press XOR-toggles a per-button region mask into an internal ROWS×COLS state. A target-row comparison produces a registered level-complete flag, and a prescaled row scanner drives the multiplexed matrix. It sits between the debounced button pins and the matrix pins, and reports to the game control unit.

## Interface
- ROWS, 8: matrix rows (2..16)
- COLS, 8: matrix columns (2..16)
- NBTN, 8: number of buttons (1..16)
- SCAN_DIV, 1024: clk cycles each row stays active (≥1)
- ROW_ACTIVE_LOW, 1: 1 means the selected row is driven 0 and the others 1; 0 means one-hot high

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- limpar  in  1  synchronous clear of matrix, move counter and lock
- botoes  in  NBTN  raw button levels (asynchronous)
- mascaras  in  NBTN*ROWS*COLS  static toggle masks; bit b*ROWS*COLS + r*COLS + c = button b toggles cell (r,c)
- linhas_alvo  in  $clog2(ROWS+1)  number of leading rows (0..k-1) that must be all-ones
- nivel_concluido  out  1  registered level-complete flag; also locks input
- jogadas  out  8  accepted-press counter, saturating at 255
- colunas  out  COLS  column drive, active-high, equals state of the scanned row
- linhas  out  ROWS  row select, polarity per ROW_ACTIVE_LOW
- db_linha  out  $clog2(ROWS)  current scan row index

## Operation
- Synchroniser: 3 flops per button (s1, s2, s3). press[b] = s2 & ~s3.
- Accepted press: press[b] is set, nivel_concluido=0, and limpar=0.
- Toggle: on each clk, state ^= XOR over all accepted b of mask[b].
  - Simultaneous presses therefore compose by XOR.
  - A cell covered by two buttons pressed in the same cycle is unchanged.
- jogadas: +1 per cycle containing ≥1 accepted press, not per button. Holds at 255.
- Lock: while nivel_concluido=1, presses are discarded. The synchroniser keeps running, so a button still held when the lock releases does not register a press.
- limpar (priority over presses):
  - state, jogadas and nivel_concluido go to 0 on the next edge.
  - Scanner and synchronisers are unaffected.
- Completion: nivel_concluido <= (linhas_alvo != 0) && rows 0..linhas_alvo-1 of state all-ones.
  - linhas_alvo > ROWS is treated as ROWS.
  - linhas_alvo changes are evaluated the same way, one cycle later.
- Scanner:
  - Prescaler counts 0..SCAN_DIV-1.
  - On terminal count, linha_atual advances and wraps ROWS-1 → 0.
  - linhas: one-hot of linha_atual, inverted if ROW_ACTIVE_LOW.
  - colunas = state[linha_atual], combinational from registers, so a toggle shows on colunas the same cycle the state changes.
- Async reset (rst_n=0):
  - Clears state, jogadas, nivel_concluido, prescaler, linha_atual and all synchroniser flops.
  - Outputs: colunas=0, jogadas=0, nivel_concluido=0, db_linha=0, linhas = ~1 (8'hFE at defaults) or 1 if ROW_ACTIVE_LOW=0.
  - Reset mid-operation discards any in-flight press.

## Timing
- Latency:
  - botoes rises before edge E1: s1=1 after E1, s2 after E2.
  - press is high between E2 and E3.
  - state and jogadas update at E3.
  - nivel_concluido updates at E4.
- A level held N cycles is one press. Minimum detectable pulse: high across one edge, then low across one edge.
- Row dwell is exactly SCAN_DIV cycles. A full frame is ROWS*SCAN_DIV cycles.
  - The first row change after reset occurs at edge SCAN_DIV.
- limpar asserted at edge E: all cleared after E.
  - A press coincident with E is discarded.
  - A completion that would have been set at E is suppressed.
- Deassert of rst_n: the first edge samples normally; no synchronous reset stage is required.

## Test plan
- Reset: rst_n=0 mid-scan with state nonzero → immediately colunas=0, linhas=8'hFE, db_linha=0, jogadas=0, nivel_concluido=0.
- Single press, defaults, mask[0]=rows 0-2 cols 0-2:
  - botoes[0] held 10 cycles → exactly one toggle at E3.
  - rows 0-2 read 8'h07, jogadas=1.
  - Second press restores 0, jogadas=2.
- Overlap: mask[2] and mask[3] share cell (5,3); press both in the same cycle → cell (5,3) unchanged, others toggled, jogadas+1 only.
- Completion and lock:
  - linhas_alvo=1, masks tiling row 0; presses filling row 0 → nivel_concluido=1 one cycle after the final toggle.
  - Further presses leave state and jogadas unchanged.
  - limpar → all 0 next edge.
  - linhas_alvo=0 → never asserts.
- Scanner: SCAN_DIV=4, ROWS=5, ROW_ACTIVE_LOW=0 → db_linha sequence 0,1,2,3,4,0 with changes every 4 cycles; linhas one-hot; colunas tracks each row's state.
- Saturation: 300 accepted presses → jogadas holds 255; limpar → 0.
